inv_sub_addkey: RTL

Iterative decryption-round front half: InvShiftRows, InvSubBytes and AddRoundKey on one 128-bit AES state.
- Sits directly upstream of inverse_mixcolumn and drives its 128-bit input.
- Processes LANES bytes per clock with computed (table-free) inverse S-boxes.
- A valid/ready handshake on both sides lets the round controller stall it.

---
 rtl/inv_sub_addkey.sv | 125 ++++++++++++
 1 files changed

// File: rtl/inv_sub_addkey.sv
// Decryption round front half: InvShiftRows, InvSubBytes and AddRoundKey on one
// 128-bit state, LANES bytes per clock, valid/ready on both sides.

module inv_sub_lane (
  input  logic [7:0] b,
  input  logic [7:0] k,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] a, x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, x254;

  assign a    = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  // a^254 == a^-1 in GF(2^8); zero stays zero without a special case
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign x254 = gmul(x252, x2);
  assign y    = x254 ^ k;
endmodule

module inv_sub_addkey #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);
  localparam int NCYC = 16 / LANES;
  localparam logic [1:0] CNT_LAST = 2'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  state_t                 state, state_nx;
  logic [1:0]             cnt;
  logic [15:0][7:0]       shifted, work, key, res, res_nx;
  logic                   last_q;
  logic [LANES-1:0][3:0]  lane_idx;
  logic [LANES-1:0][7:0]  lane_y;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[4*r+c] = in_state[8*(4*r + (c - r + 4) % 4) +: 8];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (LANES == 16) begin : g_full
      assign lane_idx[i] = 4'(i);
    end else begin : g_part
      assign lane_idx[i] = {cnt, 2'(i)};
    end
    inv_sub_lane u_lane (.b(work[lane_idx[i]]), .k(key[lane_idx[i]]), .y(lane_y[i]));
  end

  // byte j belongs to lane j%LANES during counter slot j/LANES
  for (genvar j = 0; j < 16; j++) begin : g_byte
    assign res_nx[j] = (LANES == 16 || cnt == 2'(j / 4)) ? lane_y[j % LANES] : res[j];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SUB;
      SUB:     if (cnt == CNT_LAST) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      key    <= '0;
      res    <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          work   <= shifted;
          key    <= in_key;
          last_q <= in_last;
          cnt    <= '0;
        end
        SUB: begin
          res <= res_nx;
          cnt <= (cnt == CNT_LAST) ? 2'd0 : cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == HOLD);
  assign out_state = res;
  assign out_last  = last_q;
endmodule
